// File: rtl/ila_readout_pkg.sv
// ila_readout_pkg: shared definitions for the ILA FIFO readout engine.
//   state_t        - readout FSM encoding (3-bit)
//   bytes_of()     - number of bytes needed to carry a w-bit word, ceil(w/8)
//   DEF_RD_LATENCY - FIFO registered read latency, shared with the FIFO wrapper
package ila_readout_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        POP   = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int DEF_RD_LATENCY = 2;

    function automatic int bytes_of(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/ila_fifo_readout.sv
// ila_fifo_readout: drains the capture FIFO after a capture and serializes each
// WIDTH-bit word into a little-endian byte stream (LSB byte first, last byte
// zero-padded) with a valid/ready handshake toward the host-link transmitter.
//
// Ports:
//   rclk, rst             - FIFO read clock; asynchronous active-low reset
//   start_i, abort_i      - begin readout (IDLE only) / return to IDLE at once
//   max_words_i           - word limit sampled at start, 0 = drain until empty
//   fifo_empty_i          - FIFO empty flag, looked at only before each pop
//   fifo_do_i             - FIFO read data, valid RD_LATENCY cycles after pop
//   fifo_pop_o            - one-cycle pop request, at most one outstanding
//   byte_o, byte_valid_o  - serialized byte toward the transmitter
//   byte_ready_i          - transmitter accepts byte_o
//   busy_o, done_o        - readout active / one-cycle completion pulse
//   word_cnt_o            - words fully transmitted in the current readout
module ila_fifo_readout
    import ila_readout_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int CNT_W      = 16
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] max_words_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_do_i,
    output logic             fifo_pop_o,
    output logic [7:0]       byte_o,
    output logic             byte_valid_o,
    input  logic             byte_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int BYTES = bytes_of(WIDTH);
    localparam int PADW  = BYTES * 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   limit_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [LAT_W-1:0]   wait_q;
    logic [PADW-1:0]    sh_q;
    logic [IDX_W-1:0]   idx_q;

    logic last_byte;
    logic at_limit;
    logic wait_hit;

    assign last_byte = (idx_q == IDX_W'(BYTES - 1));
    assign at_limit  = (limit_q != '0) && (cnt_q == limit_q);
    // WAIT spans RD_LATENCY cycles; the last one is where fifo_do_i is valid.
    assign wait_hit  = (wait_q == LAT_W'(1));

    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        fifo_pop_o   = 1'b0;
        byte_valid_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = CHECK;
            end
            CHECK: state_d = (fifo_empty_i || at_limit) ? DONE : POP;
            POP: begin
                fifo_pop_o = 1'b1;
                state_d    = WAIT;
            end
            WAIT: if (wait_hit) state_d = SEND;
            SEND: begin
                byte_valid_o = 1'b1;
                if (byte_ready_i && last_byte) state_d = CHECK;
            end
            DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) state_d = IDLE;
    end

    // Datapath. Abort freezes everything except the state register, so the
    // word count survives and a word in flight is simply dropped.
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            limit_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
        end else if (!abort_i) begin
            unique case (state_q)
                IDLE: if (start_i) begin
                    limit_q <= max_words_i;
                    cnt_q   <= '0;
                end
                POP: wait_q <= LAT_W'(RD_LATENCY);
                WAIT: begin
                    wait_q <= wait_q - LAT_W'(1);
                    if (wait_hit) begin
                        sh_q  <= PADW'(fifo_do_i);
                        idx_q <= '0;
                    end
                end
                SEND: if (byte_ready_i) begin
                    // Shift right so the next byte always sits in sh_q[7:0].
                    sh_q <= sh_q >> 8;
                    if (last_byte) begin
                        idx_q <= '0;
                        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_o     = sh_q[7:0];
    assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_ila_fifo_readout.sv
`timescale 1ns/1ps
module tb_ila_fifo_readout;

    localparam int BYTES = 3;

    logic        rclk = 1'b0;
    logic        rst  = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0;
    logic [15:0] max_words_i = '0;
    logic        fifo_empty_i = 1'b1;
    logic [19:0] fifo_do_i = '0;
    logic        fifo_pop_o, byte_valid_o, busy_o, done_o;
    logic [7:0]  byte_o;
    logic        byte_ready_i = 1'b0;
    logic [15:0] word_cnt_o;

    // second instance with a read latency that disagrees with its FIFO model
    logic        start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b1;
    logic        fifo_empty2 = 1'b0;
    logic [19:0] fifo_do2 = '0;
    logic        pop2, valid2, busy2, done2;
    logic [7:0]  byte2;
    logic [15:0] wcnt2;
    localparam logic [19:0] W2 = 20'h5A3C1;

    ila_fifo_readout #(.WIDTH(20), .RD_LATENCY(2), .CNT_W(16)) dut (
        .rclk(rclk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .max_words_i(max_words_i), .fifo_empty_i(fifo_empty_i), .fifo_do_i(fifo_do_i),
        .fifo_pop_o(fifo_pop_o), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i), .busy_o(busy_o), .done_o(done_o),
        .word_cnt_o(word_cnt_o));

    ila_fifo_readout #(.WIDTH(20), .RD_LATENCY(3), .CNT_W(16)) dut_l3 (
        .rclk(rclk), .rst(rst), .start_i(start2), .abort_i(abort2),
        .max_words_i(16'd1), .fifo_empty_i(fifo_empty2), .fifo_do_i(fifo_do2),
        .fifo_pop_o(pop2), .byte_o(byte2), .byte_valid_o(valid2),
        .byte_ready_i(ready2), .busy_o(busy2), .done_o(done2),
        .word_cnt_o(wcnt2));

    always #5 rclk = ~rclk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge rclk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- FIFO model: data valid exactly 2 cycles after pop ----------------
    logic [19:0] fq[$];
    int          pend = 0, pops = 0;
    logic [19:0] pend_w = '0;
    bit          hit;
    always @(negedge rclk) begin
        hit = 1'b0;
        if (!rst) pend = 0;
        else if (fifo_pop_o) begin
            pend = 2;
            pops++;
            if (fq.size() > 0) pend_w = fq.pop_front();
        end else if (pend > 0) begin
            pend--;
            hit = (pend == 0);
        end
        fifo_do_i    = hit ? pend_w : ~pend_w;   // garbage outside the valid cycle
        fifo_empty_i = (fq.size() == 0);
    end

    int  pend2 = 0, pops2 = 0;
    bit  hit2;
    always @(negedge rclk) begin
        hit2 = 1'b0;
        if (!rst) pend2 = 0;
        else if (pop2) begin pend2 = 2; pops2++; end
        else if (pend2 > 0) begin pend2--; hit2 = (pend2 == 0); end
        fifo_do2    = hit2 ? W2 : ~W2;
        fifo_empty2 = (pops2 >= 1);
    end

    // ---------------- ready driver ----------------
    int rdy_mode = 0;   // 0 high, 1 toggle, 2 random, 3 low
    always @(posedge rclk) begin
        #2;
        case (rdy_mode)
            0: byte_ready_i = 1'b1;
            1: byte_ready_i = ~byte_ready_i;
            2: byte_ready_i = 1'($urandom_range(0, 1));
            default: byte_ready_i = 1'b0;
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    logic [7:0] exp_q[$];
    int   acc_cnt = 0, done_cnt = 0, done_cyc = -1, first_acc_cyc = -1, last_acc_cyc = -1;
    int   vld_seen = 0, stalls = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_byte = '0;
    always @(negedge rclk) begin
        if (!rst) prev_stall = 0;
        else begin
            if (prev_stall) chk("hold_stable", {byte_valid_o, byte_o}, {1'b1, prev_byte});
            if (byte_valid_o && byte_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_byte: got %0h expected none", byte_o);
                end else chk("byte", byte_o, exp_q.pop_front());
                acc_cnt++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
            end
            if (byte_valid_o) vld_seen++;
            if (byte_valid_o && !byte_ready_i) stalls++;
            if (done_o) begin done_cnt++; done_cyc = cyc; end
            prev_stall = byte_valid_o && !byte_ready_i && !abort_i;
            prev_byte  = byte_o;
        end
    end

    logic [23:0] cap2 = '0;
    int k2 = 0, done2_cnt = 0;
    always @(negedge rclk) begin
        if (rst) begin
            if (valid2 && ready2) begin cap2 = cap2 | (24'(byte2) << (8 * k2)); k2++; end
            if (done2) done2_cnt++;
        end
    end

    // ---------------- reference model + stimulus helpers ----------------
    int done_base, pops_base, acc_base, vld_base, s_cyc, exp_words;

    task automatic push_exp(input logic [19:0] w);
        int unsigned v;
        v = w;
        for (int i = 0; i < BYTES; i++) exp_q.push_back(8'((v >> (8 * i)) % 256));
    endtask

    task automatic start_readout(input int limit, input bit model);
        int n;
        n = (limit == 0 || limit > fq.size()) ? fq.size() : limit;
        exp_words = n;
        if (model) for (int i = 0; i < n; i++) push_exp(fq[i]);
        done_base = done_cnt; pops_base = pops; acc_base = acc_cnt; vld_base = vld_seen;
        first_acc_cyc = -1;
        @(posedge rclk); #1;
        max_words_i = 16'(limit); start_i = 1'b1; s_cyc = cyc;
        @(posedge rclk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == done_base && n < budget) begin @(posedge rclk); #1; n++; end
        chk(name, done_cnt - done_base, 1);
    endtask

    initial begin
        int n, lim, sz0;
        logic [19:0] w;

        repeat (3) @(posedge rclk);
        @(negedge rclk);
        chk("rst_byte", byte_o, 0);
        chk("rst_valid", byte_valid_o, 0);
        chk("rst_pop", fifo_pop_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_wcnt", word_cnt_o, 0);
        @(posedge rclk); #1 rst = 1'b1;
        repeat (2) @(posedge rclk);

        // 1: single word, exact pipeline timing
        fq.push_back(20'hABCDE);
        start_readout(0, 1);
        wait_done("t1_done", 60);
        chk("t1_pops", pops - pops_base, 1);
        chk("t1_wcnt", word_cnt_o, 1);
        chk("t1_first_byte_cyc", first_acc_cyc - s_cyc, 5);
        chk("t1_last_byte_cyc", last_acc_cyc - s_cyc, 7);
        chk("t1_done_cyc", done_cyc - s_cyc, 9);
        chk("t1_drained", exp_q.size(), 0);

        // 2: word limit below FIFO occupancy
        fq.delete();
        for (int i = 0; i < 5; i++) fq.push_back(20'($urandom()));
        start_readout(3, 1);
        wait_done("t2_done", 200);
        chk("t2_pops", pops - pops_base, 3);
        chk("t2_bytes", acc_cnt - acc_base, 9);
        chk("t2_wcnt", word_cnt_o, 3);
        chk("t2_left", fq.size(), 2);
        chk("t2_not_empty", fifo_empty_i, 0);

        // 3: ready toggling every cycle
        fq.delete();
        fq.push_back(20'hABCDE);
        rdy_mode = 1;
        stalls = 0;
        start_readout(0, 1);
        wait_done("t3_done", 100);
        chk("t3_wcnt", word_cnt_o, 1);
        chk("t3_stalled", stalls > 0, 1);
        chk("t3_drained", exp_q.size(), 0);
        rdy_mode = 0;

        // 4: start with FIFO empty
        fq.delete();
        repeat (2) @(posedge rclk);
        start_readout(0, 1);
        wait_done("t4_done", 20);
        chk("t4_done_cyc", done_cyc - s_cyc, 2);
        chk("t4_pops", pops - pops_base, 0);
        chk("t4_wcnt", word_cnt_o, 0);
        chk("t4_no_valid", vld_seen - vld_base, 0);

        // 5: abort after first byte of the second word, then resume
        for (int i = 0; i < 4; i++) fq.push_back(20'($urandom()));
        push_exp(fq[0]);
        exp_q.push_back(8'(fq[1]));
        start_readout(0, 0);
        n = 0;
        while (acc_cnt < acc_base + 4 && n < 60) begin @(posedge rclk); #1; n++; end
        chk("t5_reach_word2", acc_cnt - acc_base, 4);
        abort_i = 1'b1; rdy_mode = 3;
        @(posedge rclk); #1;
        abort_i = 1'b0; rdy_mode = 0;
        chk("t5_valid_low", byte_valid_o, 0);
        chk("t5_busy_low", busy_o, 0);
        chk("t5_wcnt", word_cnt_o, 1);
        chk("t5_left", fq.size(), 2);
        repeat (4) @(posedge rclk);
        chk("t5_no_done", done_cnt - done_base, 0);
        chk("t5_drained", exp_q.size(), 0);
        start_readout(0, 1);
        wait_done("t5_resume_done", 120);
        chk("t5_resume_wcnt", word_cnt_o, 2);
        chk("t5_resume_drained", exp_q.size(), 0);

        // 6: sampling point - a latency-3 engine on a latency-2 FIFO reads garbage
        @(posedge rclk); #1 start2 = 1'b1;
        @(posedge rclk); #1 start2 = 1'b0;
        n = 0;
        while (done2_cnt == 0 && n < 60) begin @(posedge rclk); #1; n++; end
        chk("t6_done", done2_cnt, 1);
        chk("t6_bytes", k2, 3);
        chk("t6_mismatch_flagged", cap2 != {4'h0, W2}, 1);
        chk("t6_garbage_word", cap2, {4'h0, ~W2});

        // random rounds against the queue model
        for (int r = 0; r < 8; r++) begin
            fq.delete();
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin w = 20'($urandom()); fq.push_back(w); end
            lim = $urandom_range(0, 4);
            rdy_mode = $urandom_range(0, 2);
            sz0 = fq.size();
            start_readout(lim, 1);
            wait_done("rnd_done", 600);
            chk("rnd_wcnt", word_cnt_o, exp_words);
            chk("rnd_left", fq.size(), sz0 - exp_words);
            chk("rnd_drained", exp_q.size(), 0);
        end
        rdy_mode = 0;

        // reset in the middle of a transfer
        fq.delete();
        fq.push_back(20'h12345); fq.push_back(20'h6789A);
        start_readout(0, 1);
        n = 0;
        while (acc_cnt == acc_base && n < 40) begin @(posedge rclk); #1; n++; end
        chk("rst_mid_started", byte_valid_o, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", byte_valid_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_wcnt", word_cnt_o, 0);
        exp_q.delete();
        fq.delete();
        repeat (2) @(posedge rclk);
        #1 rst = 1'b1;
        repeat (3) @(posedge rclk);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ila_fifo_readout.md
Name: ila_fifo_readout

Overview:
Drains the cascaded capture FIFO after a capture completes and serializes each WIDTH-bit sample into a little-endian byte stream for the host link (UART/SPI transmitter).
Sits directly downstream of the FIFO read port, in the FIFO read-clock domain.
Keeps at most one FIFO pop outstanding and honours the FIFO's registered read latency.
Uses a valid/ready byte handshake toward the transmitter.

Parameters:
WIDTH, 20, FIFO data width in bits (1..80)
RD_LATENCY, 2, cycles from fifo_pop_o high to fifo_do_i valid
CNT_W, 16, width of word-count limit and counter

Ports:
rclk  in  1  single clock (FIFO read clock)
rst  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse, begin readout; honoured only in IDLE
abort_i  in  1  return to IDLE from any state, next edge
max_words_i  in  CNT_W  word limit, sampled at start_i; 0 = drain until empty
fifo_empty_i  in  1  FIFO EMPTY flag
fifo_do_i  in  WIDTH  FIFO read data
fifo_pop_o  out  1  FIFO POP request, one-cycle pulse
byte_o  out  8  serialized byte
byte_valid_o  out  1  byte_o valid
byte_ready_i  in  1  transmitter accepts byte
busy_o  out  1  high in any state except IDLE/DONE
done_o  out  1  one-cycle pulse on entering DONE
word_cnt_o  out  CNT_W  words fully transmitted in the current readout

Behaviour:
- Interface (decided): one clock rclk; rst asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; shift register, counters and byte index 0.
- BYTES = ceil(WIDTH/8). A word is sent LSB byte first. The last byte is zero-padded above bit WIDTH-1.
- IDLE:
  - start_i=1: latch limit=max_words_i, clear word_cnt_o, go to CHECK.
- CHECK:
  - if fifo_empty_i=1, or (limit!=0 and word_cnt_o==limit): go to DONE.
  - else: go to POP.
- POP: fifo_pop_o=1 for exactly this cycle; load wait counter with RD_LATENCY; go to WAIT.
- WAIT: decrement the wait counter. On the cycle it reaches 0, capture fifo_do_i into the shift register, set byte index 0, go to SEND. fifo_do_i is therefore sampled exactly RD_LATENCY cycles after the POP cycle.
- SEND:
  - byte_valid_o=1; byte_o = current byte.
  - byte_o is held stable while byte_valid_o=1 and byte_ready_i=0.
  - On valid&ready: advance the byte index.
  - On acceptance of byte BYTES-1: increment word_cnt_o, deassert valid next cycle, go to CHECK.
  - Minimum per-word cost with ready held high: 1 (CHECK) + 1 (POP) + RD_LATENCY + BYTES cycles.
- DONE: done_o pulses for one cycle; go to IDLE. word_cnt_o holds its value until the next start_i.
- abort_i has priority over every transition. Next state IDLE; byte_valid_o and fifo_pop_o drop on the next edge; word_cnt_o is kept; no done_o pulse. A pop already issued is not compensated (its word is lost).
- start_i outside IDLE is ignored. start_i and abort_i asserted in the same cycle: abort wins; stay IDLE.
- fifo_empty_i is evaluated only in CHECK. Empty rising during WAIT/SEND does not affect the current word.
- word_cnt_o saturates at 2^CNT_W-1 (no wrap) when limit=0.
- Reset asserted mid-transfer: immediate return to reset values; byte_valid_o drops asynchronously.

Decomposition:
- Package ila_readout_pkg holds:
  - state encoding: IDLE, CHECK, POP, WAIT, SEND, DONE (3-bit);
  - a BYTES constant function ceil(w/8);
  - the default RD_LATENCY value shared with the FIFO wrapper.
- Single module; no sub-module. The byte shifter is a few lines of index muxing and does not warrant its own module.

Test Plan:
1. WIDTH=20, FIFO holds 0xABCDE, max_words_i=0, ready=1 → bytes 0xDE, 0xBC, 0x0A in order; fifo_pop_o pulsed once; done_o pulses after empty re-check; word_cnt_o=1.
2. FIFO holds 5 words, max_words_i=3 → exactly 3 pops, 9 bytes, done_o, word_cnt_o=3; 2 words remain (fifo_empty_i still 0).
3. Ready throttling: byte_ready_i toggles 0/1 every cycle → byte_o stable while valid&!ready; no byte dropped or duplicated; order identical to test 1.
4. start_i with fifo_empty_i=1 → no pop; done_o two cycles after start; word_cnt_o=0; byte_valid_o never high.
5. abort_i mid-SEND (after first byte of word 2) → IDLE next edge; byte_valid_o=0; no done_o; word_cnt_o=1; a fresh start_i resumes with the next FIFO word.
6. Latency check: RD_LATENCY=2, FIFO model drives data exactly 2 cycles after pop and garbage otherwise → captured word correct. With RD_LATENCY=3 on the same model → mismatch flagged (negative check of the sampling point).
